board_move_writer: RTL and testbench
====================================

# board_move_writer

Owns the authoritative 64-square board register and applies moves to it; it is the write-side counterpart of the board scanners, which only read the board. It accepts one move at a time over a valid/ready handshake, checks it, and writes the result back. It reports any captured piece and tracks side-to-move. Its `bigBoard` output feeds every scanner and the display path.

## Interface
- No parameters; all encodings come from the shared package.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `init` in 1: reload the start position (sampled in IDLE only).
- `move_valid` in 1: move request present.
- `move_ready` out 1: block can accept a move.
- `from_pos` in 6: source square, index = row*8+col.
- `to_pos` in 6: destination square.
- `promo_piece` in 3: requested promotion type.
- `bigBoard` out 256: square i occupies bits [4i+3:4i]; bit3 = color (0 white, 1 black); [2:0] = type.
- `side_to_move` out 1: 0 white, 1 black.
- `done` out 1: one-cycle pulse when a move completes (accepted or rejected).
- `error` out 1: valid only while `done`; 1 = move rejected, board unchanged.
- `captured_piece` out 4: valid while `done`; 4'b0000 if nothing was captured or the move was rejected.

## Operation
- Piece types: 000 empty, 001 pawn, 010 knight, 011 bishop, 100 rook, 101 queen, 110 king; 111 is illegal.
- Start position:
  - Row 0: black back rank, cols 0–7 = R N B Q K B N R.
  - Row 1: black pawns.
  - Row 6: white pawns.
  - Row 7: white back rank, same order as row 0.
  - All other squares empty.
- Reset:
  - `bigBoard` = start position, `side_to_move` = 0.
  - State IDLE, so `move_ready` = 1 from the first cycle after reset.
  - `done` = 0, `error` = 0, `captured_piece` = 0.
- State machine: IDLE → FETCH → CHECK → WRITE → DONE → IDLE. CHECK goes straight to DONE on error.
- IDLE:
  - `move_ready` = 1; it is 0 in every other state.
  - If `init`: reload the start position, set `side_to_move` = 0, stay in IDLE. `init` wins over `move_valid` in the same cycle, and no handshake occurs.
  - Otherwise, if `move_valid`: latch `from_pos`, `to_pos`, `promo_piece` and go to FETCH.
- FETCH: latch `src` = board[from] and `dst` = board[to].
- CHECK: the move is rejected if any of these holds:
  - `src` type is 000 or 111;
  - `from` == `to`;
  - `src` color != `side_to_move`;
  - `dst` is non-empty and has the same color as `src`.
- WRITE:
  - Write board[from] = 0000.
  - Write board[to] = `src`, with one exception: a pawn reaching its promotion row (white pawn to row 0, black pawn to row 7) becomes `{src color, p}`.
  - p = `promo_piece` if it is in 010..101; otherwise p = 101 (queen).
  - Set `captured_piece` = `dst`.
  - Toggle `side_to_move`.
- DONE: `done` = 1 for exactly this cycle, with `error` and `captured_piece` held stable.
- Outside the DONE cycle, `done`, `error` and `captured_piece` read 0.
- Legality of piece movement geometry is out of scope; the move generator upstream guarantees it.
- `init` or `move_valid` in any non-IDLE state is ignored.

## Timing
- Handshake: a transfer occurs on the edge where `move_valid` && `move_ready`. The requester must hold its inputs stable until that edge.
- Accepted move, transfer at edge E0:
  - FETCH after E0, CHECK after E1, WRITE after E2.
  - `bigBoard` updated at E3; `done` high during E3→E4, at the same time as the new board.
  - `move_ready` returns to 1 after E4.
  - Throughput: one move per 5 cycles.
- Rejected move: `done` with `error` = 1 during E2→E3; board and `side_to_move` unchanged.
- `init` in IDLE at edge E: new board visible after E, with no `done` pulse.
- `rst_n` low mid-move at any edge: the move is abandoned, no `done` is issued, and all reset values are applied at that edge.

## Structure
- Shared package `chess_pkg` holds:
  - piece-type localparams and the color bit index;
  - the 256-bit `START_BOARD` constant (also used by benches);
  - the state encoding.
- One sub-module is natural: `move_check`, purely combinational.
  - Inputs: `src`, `dst`, `from_pos`, `to_pos`, `side_to_move`, `promo_piece`.
  - Outputs: `reject` and the resolved destination code.

## Test plan
- Reset, then move 52→36 (white pawn): `done` at E0+3 with `error` = 0, `captured_piece` = 0; `bigBoard[147:144]` = 0001, `bigBoard[211:208]` = 0000; `side_to_move` = 1.
- Move 12→28 (black pawn) as the first move after reset: `done` at E0+2 with `error` = 1; board equals `START_BOARD`; `side_to_move` = 0.
- Capture: from start, apply 52→36, 11→27, 36→27: the last move returns `captured_piece` = 1001; square 27 = 0001.
- Promotion: `init`, then build a white pawn on 8 with square 0 empty via moves; move 8→0 with `promo_piece` = 010 → square 0 = 0010. Repeat with `promo_piece` = 000 → square 0 = 0101.
- Same-color capture 63→62 from start, and `from` == `to` (52→52): both give `error` = 1, no board change.
- `init` and `move_valid` together in IDLE: board = `START_BOARD`, no handshake. Assert `rst_n` low during WRITE: no `done`; board = `START_BOARD`; `move_ready` = 1 on the next cycle.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared chess encodings: piece types, color bit, FSM state codes and the start position.
package chess_pkg;

  localparam logic [2:0] PieceEmpty   = 3'b000;
  localparam logic [2:0] PiecePawn    = 3'b001;
  localparam logic [2:0] PieceKnight  = 3'b010;
  localparam logic [2:0] PieceBishop  = 3'b011;
  localparam logic [2:0] PieceRook    = 3'b100;
  localparam logic [2:0] PieceQueen   = 3'b101;
  localparam logic [2:0] PieceKing    = 3'b110;
  localparam logic [2:0] PieceIllegal = 3'b111;

  localparam int unsigned ColorBit = 3;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StFetch = 3'd1;
  localparam logic [2:0] StCheck = 3'd2;
  localparam logic [2:0] StWrite = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  function automatic logic [2:0] back_rank(input int unsigned col);
    case (col)
      0, 7:    back_rank = PieceRook;
      1, 6:    back_rank = PieceKnight;
      2, 5:    back_rank = PieceBishop;
      3:       back_rank = PieceQueen;
      default: back_rank = PieceKing;
    endcase
  endfunction

  function automatic logic [255:0] start_board();
    logic [255:0] b;
    b = '0;
    for (int unsigned c = 0; c < 8; c++) begin
      b[4*c +: 4]        = {1'b1, back_rank(c)};
      b[4*(8 + c) +: 4]  = {1'b1, PiecePawn};
      b[4*(48 + c) +: 4] = {1'b0, PiecePawn};
      b[4*(56 + c) +: 4] = {1'b0, back_rank(c)};
    end
    return b;
  endfunction

  localparam logic [255:0] START_BOARD = start_board();

endpackage

// File: rtl/move_check.sv
// Combinational move validation and destination-code resolution (pawn promotion).
module move_check
  import chess_pkg::*;
(
  input  logic [3:0] src,
  input  logic [3:0] dst,
  input  logic [5:0] from_pos,
  input  logic [5:0] to_pos,
  input  logic       side_to_move,
  input  logic [2:0] promo_piece,
  output logic       reject,
  output logic [3:0] dst_code
);

  logic [2:0] src_type;
  logic       src_color;
  logic       promo_row;
  logic [2:0] promo_type;

  always_comb begin
    src_type  = src[2:0];
    src_color = src[ColorBit];

    reject = (src_type == PieceEmpty) || (src_type == PieceIllegal) ||
             (from_pos == to_pos) || (src_color != side_to_move) ||
             ((dst[2:0] != PieceEmpty) && (dst[ColorBit] == src_color));

    // White promotes on row 0, black on row 7.
    promo_row  = src_color ? (to_pos[5:3] == 3'd7) : (to_pos[5:3] == 3'd0);
    promo_type = ((promo_piece >= PieceKnight) && (promo_piece <= PieceQueen)) ?
                 promo_piece : PieceQueen;

    dst_code = ((src_type == PiecePawn) && promo_row) ? {src_color, promo_type} : src;
  end

endmodule

// File: rtl/board_move_writer.sv
// Owns the 64-square board register; accepts one move per handshake, validates and applies it.
module board_move_writer
  import chess_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         init,
  input  logic         move_valid,
  output logic         move_ready,
  input  logic [5:0]   from_pos,
  input  logic [5:0]   to_pos,
  input  logic [2:0]   promo_piece,
  output logic [255:0] bigBoard,
  output logic         side_to_move,
  output logic         done,
  output logic         error,
  output logic [3:0]   captured_piece
);

  logic [2:0]   state_q, state_d;
  logic [5:0]   from_q, to_q;
  logic [2:0]   promo_q;
  logic [3:0]   src_q, dst_q;
  logic [255:0] board_q;
  logic         side_q;
  logic         error_q;
  logic [3:0]   captured_q;

  logic         reject;
  logic [3:0]   dst_code;

  move_check u_move_check (
    .src          (src_q),
    .dst          (dst_q),
    .from_pos     (from_q),
    .to_pos       (to_q),
    .side_to_move (side_q),
    .promo_piece  (promo_q),
    .reject       (reject),
    .dst_code     (dst_code)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (!init && move_valid) state_d = StFetch;
      StFetch: state_d = StCheck;
      StCheck: state_d = reject ? StDone : StWrite;
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      from_q     <= '0;
      to_q       <= '0;
      promo_q    <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      board_q    <= START_BOARD;
      side_q     <= 1'b0;
      error_q    <= 1'b0;
      captured_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (init) begin
            board_q <= START_BOARD;
            side_q  <= 1'b0;
          end else if (move_valid) begin
            from_q  <= from_pos;
            to_q    <= to_pos;
            promo_q <= promo_piece;
          end
        end
        StFetch: begin
          src_q <= board_q[{from_q, 2'b00} +: 4];
          dst_q <= board_q[{to_q, 2'b00} +: 4];
        end
        StCheck: begin
          error_q    <= reject;
          captured_q <= '0;
        end
        StWrite: begin
          // from != to is guaranteed here, so the two slice writes never collide.
          board_q[{from_q, 2'b00} +: 4] <= 4'b0000;
          board_q[{to_q, 2'b00} +: 4]   <= dst_code;
          captured_q                    <= dst_q;
          side_q                        <= ~side_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    move_ready     = (state_q == StIdle);
    done           = (state_q == StDone);
    error          = done & error_q;
    captured_piece = done ? captured_q : 4'b0000;
    bigBoard       = board_q;
    side_to_move   = side_q;
  end

endmodule

// File: tb/tb_board_move_writer.sv
// Randomised scoreboard bench for board_move_writer against a square-array chess model.
module tb_board_move_writer;
  import chess_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         init = 1'b0;
  logic         move_valid = 1'b0;
  logic         move_ready;
  logic [5:0]   from_pos = '0;
  logic [5:0]   to_pos = '0;
  logic [2:0]   promo_piece = '0;
  logic [255:0] bigBoard;
  logic         side_to_move;
  logic         done;
  logic         error;
  logic [3:0]   captured_piece;

  board_move_writer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .init           (init),
    .move_valid     (move_valid),
    .move_ready     (move_ready),
    .from_pos       (from_pos),
    .to_pos         (to_pos),
    .promo_piece    (promo_piece),
    .bigBoard       (bigBoard),
    .side_to_move   (side_to_move),
    .done           (done),
    .error          (error),
    .captured_piece (captured_piece)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int xfer_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic         err;
    logic [3:0]   cap;
    logic [255:0] board;
    logic         side;
    int           lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  logic [3:0]   mb[64];
  logic         mside;
  logic [255:0] start_v;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [255:0] pack_model();
    logic [255:0] b;
    for (int i = 0; i < 64; i++) b[4*i +: 4] = mb[i];
    return b;
  endfunction

  task automatic model_reset();
    start_v = START_BOARD;
    for (int i = 0; i < 64; i++) mb[i] = start_v[4*i +: 4];
    mside = 1'b0;
  endtask

  // Chess rules applied directly to the square array.
  task automatic model_move(input int f, input int t, input int p, output exp_t e);
    logic [3:0] s, d, put;
    bit rej;
    s = mb[f];
    d = mb[t];
    rej = (s[2:0] == 3'd0) || (s[2:0] == 3'd7) || (f == t) || (s[3] != mside) ||
          ((d[2:0] != 3'd0) && (d[3] == s[3]));
    if (rej) begin
      e.err = 1'b1;
      e.cap = 4'd0;
      e.lat = 2;
    end else begin
      put = s;
      if (s[2:0] == 3'd1 && ((s[3] == 1'b0 && t / 8 == 0) || (s[3] == 1'b1 && t / 8 == 7)))
        put = {s[3], (p >= 2 && p <= 5) ? 3'(p) : 3'd5};
      mb[f] = 4'd0;
      mb[t] = put;
      mside = ~mside;
      e.err = 1'b0;
      e.cap = d;
      e.lat = 3;
    end
    e.board = pack_model();
    e.side  = mside;
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        mon_e = sb.pop_front();
        check("error", error, mon_e.err);
        check("captured", captured_piece, mon_e.cap);
        check("board", bigBoard, mon_e.board);
        check("side", side_to_move, mon_e.side);
        check("latency", cyc - xfer_cyc, mon_e.lat);
      end
    end else begin
      check("idle_outputs", {error, captured_piece}, 5'd0);
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!move_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!move_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
  endtask

  task automatic do_move(input int f, input int t, input int p);
    exp_t e;
    wait_ready();
    if (!move_ready) return;
    from_pos    = 6'(f);
    to_pos      = 6'(t);
    promo_piece = 3'(p);
    move_valid  = 1'b1;
    @(posedge clk);
    #1;
    xfer_cyc   = cyc;
    move_valid = 1'b0;
    model_move(f, t, p, e);
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_init();
    wait_ready();
    init = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    sb.delete();
    @(negedge clk);
  endtask

  initial begin
    int src_list[$];
    int f, t;
    start_v = START_BOARD;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_board", bigBoard, start_v);
    check("rst_side", side_to_move, 1'b0);
    check("rst_ready", move_ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_captured", captured_piece, 4'd0);

    // White pawn push.
    do_move(52, 36, 0);
    drain();
    check("sq36", bigBoard[147:144], 4'b0001);
    check("sq52", bigBoard[211:208], 4'b0000);
    check("side_after_white", side_to_move, 1'b1);

    // Black moves first: rejected.
    do_reset();
    do_move(12, 28, 0);
    drain();
    check("reject_board", bigBoard, start_v);
    check("reject_side", side_to_move, 1'b0);

    // Capture of a black pawn.
    do_reset();
    do_move(52, 36, 0);
    do_move(11, 27, 0);
    do_move(36, 27, 0);
    drain();
    check("sq27_capture", bigBoard[111:108], 4'b0001);

    // Promotion to knight, then default promotion to queen.
    do_init();
    do_move(48, 8, 0);
    do_move(0, 16, 0);
    do_move(8, 0, 2);
    drain();
    check("promo_knight", bigBoard[3:0], 4'b0010);
    do_init();
    do_move(48, 8, 0);
    do_move(0, 16, 0);
    do_move(8, 0, 0);
    drain();
    check("promo_queen", bigBoard[3:0], 4'b0101);

    // Same-color capture and null move.
    do_init();
    do_move(63, 62, 0);
    do_move(52, 52, 0);
    drain();
    check("same_color_board", bigBoard, start_v);

    // init wins over move_valid: no handshake, no done.
    do_move(52, 36, 0);
    drain();
    wait_ready();
    init        = 1'b1;
    move_valid  = 1'b1;
    from_pos    = 6'd51;
    to_pos      = 6'd35;
    @(posedge clk);
    #1;
    init       = 1'b0;
    move_valid = 1'b0;
    model_reset();
    @(negedge clk);
    check("init_board", bigBoard, start_v);
    check("init_side", side_to_move, 1'b0);
    check("init_no_handshake", move_ready, 1'b1);
    repeat (5) @(negedge clk);

    // Reset asserted while in WRITE.
    from_pos   = 6'd52;
    to_pos     = 6'd36;
    move_valid = 1'b1;
    @(posedge clk);
    #1;
    move_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check("rst_mid_ready", move_ready, 1'b1);
    check("rst_mid_board", bigBoard, start_v);
    check("rst_mid_done", done, 1'b0);
    repeat (5) @(negedge clk);

    // Random play, mostly moves by the side to move.
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 39) == 0) do_init();
      src_list.delete();
      for (int i = 0; i < 64; i++)
        if (mb[i][2:0] != 3'd0 && mb[i][3] == mside) src_list.push_back(i);
      if (src_list.size() > 0 && $urandom_range(0, 9) < 7)
        f = src_list[$urandom_range(0, src_list.size() - 1)];
      else
        f = int'($urandom_range(0, 63));
      t = int'($urandom_range(0, 63));
      do_move(f, t, int'($urandom_range(0, 7)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    check("final_board", bigBoard, pack_model());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
